// File: rtl/cache_arb_pkg.sv
// Shared types and default widths for the L1-to-adaptor cacheline arbiter.
package cache_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;

  // Round-robin pick. On a tie, the side that was not served last wins.
  // The result is only meaningful when at least one side is pending.
  function automatic requester_t rr_pick(input logic i_pend, input logic d_pend,
                                         input requester_t last);
    if (i_pend && d_pend) begin
      return (last == REQ_D) ? REQ_I : REQ_D;
    end
    return d_pend ? REQ_D : REQ_I;
  endfunction

endpackage

// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter that shares one cacheline adaptor between the I-cache and the D-cache.
// The winner's request is latched at grant and its response is routed back combinationally.
module cacheline_arbiter #(
  parameter int unsigned ADDR_W = cache_arb_pkg::ADDR_W,
  parameter int unsigned LINE_W = cache_arb_pkg::LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_line,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wline,
  output logic [LINE_W-1:0] d_line,
  output logic              d_resp,
  output logic              a_read,
  output logic              a_write,
  output logic [ADDR_W-1:0] a_addr,
  output logic [LINE_W-1:0] a_wline,
  input  logic [LINE_W-1:0] a_line,
  input  logic              a_resp
);

  import cache_arb_pkg::*;

  arb_state_t        state_q;
  requester_t        last_q;
  logic              op_wr_q;
  logic [ADDR_W-1:0] op_addr_q;
  logic [LINE_W-1:0] op_line_q;

  logic i_pend;
  logic d_pend;
  logic busy;

  assign i_pend = i_read;
  assign d_pend = d_read | d_write;
  assign busy   = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= REQ_D;
      op_wr_q   <= 1'b0;
      op_addr_q <= '0;
      op_line_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_pend || d_pend) begin
            if (rr_pick(i_pend, d_pend, last_q) == REQ_I) begin
              state_q   <= BUSY_I;
              op_wr_q   <= 1'b0;
              op_addr_q <= i_addr;
            end else begin
              state_q   <= BUSY_D;
              // d_write dominates an illegal read+write combination.
              op_wr_q   <= d_write;
              op_addr_q <= d_addr;
              if (d_write) begin
                op_line_q <= d_wline;
              end
            end
          end
        end
        BUSY_I, BUSY_D: begin
          // Completion always returns to IDLE for one cycle so a requester can drop its request.
          if (a_resp) begin
            last_q  <= (state_q == BUSY_D) ? REQ_D : REQ_I;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_read  = busy & ~op_wr_q;
  assign a_write = busy & op_wr_q;
  assign a_addr  = op_addr_q;
  assign a_wline = op_line_q;

  assign i_resp = (state_q == BUSY_I) & a_resp;
  assign d_resp = (state_q == BUSY_D) & a_resp;

  assign i_line = a_line;
  assign d_line = a_line;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Self-checking bench for cacheline_arbiter: an ownership/transaction model checked every cycle
// plus directed scenarios with literal expectations.
module tb_cacheline_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;

  logic          clk;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_line;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wline;
  logic [LW-1:0] d_line;
  logic          d_resp;
  logic          a_read;
  logic          a_write;
  logic [AW-1:0] a_addr;
  logic [LW-1:0] a_wline;
  logic [LW-1:0] a_line;
  logic          a_resp;

  int checks;
  int errors;

  cacheline_arbiter #(
    .ADDR_W(AW),
    .LINE_W(LW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i_read (i_read),
    .i_addr (i_addr),
    .i_line (i_line),
    .i_resp (i_resp),
    .d_read (d_read),
    .d_write(d_write),
    .d_addr (d_addr),
    .d_wline(d_wline),
    .d_line (d_line),
    .d_resp (d_resp),
    .a_read (a_read),
    .a_write(a_write),
    .a_addr (a_addr),
    .a_wline(a_wline),
    .a_line (a_line),
    .a_resp (a_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: who owns the adaptor (0 none, 1 I, 2 D), who was served last, and the latched request.
  int            m_owner;
  bit            m_last_d;
  bit            m_wr;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_line;
  int            grants[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner  <= 0;
      m_last_d <= 1'b1;
      m_wr     <= 1'b0;
      m_addr   <= '0;
      m_line   <= '0;
    end else if (m_owner == 0) begin
      if (i_read && (!(d_read || d_write) || m_last_d)) begin
        m_owner <= 1;
        m_wr    <= 1'b0;
        m_addr  <= i_addr;
        grants.push_back(1);
      end else if (d_read || d_write) begin
        m_owner <= 2;
        m_wr    <= d_write;
        m_addr  <= d_addr;
        if (d_write) m_line <= d_wline;
        grants.push_back(2);
      end
    end else if (a_resp) begin
      m_last_d <= (m_owner == 2);
      m_owner  <= 0;
    end
  end

  always @(negedge clk) begin
    chk("cyc_a_read", LW'(a_read), LW'(m_owner != 0 && !m_wr));
    chk("cyc_a_write", LW'(a_write), LW'(m_owner != 0 && m_wr));
    chk("cyc_i_resp", LW'(i_resp), LW'(m_owner == 1 && a_resp));
    chk("cyc_d_resp", LW'(d_resp), LW'(m_owner == 2 && a_resp));
    chk("cyc_i_line", i_line, a_line);
    chk("cyc_d_line", d_line, a_line);
    if (m_owner != 0) chk("cyc_a_addr", LW'(a_addr), LW'(m_addr));
    if (m_owner != 0 && m_wr) chk("cyc_a_wline", a_wline, m_line);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for an adaptor request, hold it for lat cycles, then pulse a_resp and check routing.
  task automatic serve(input int lat, input int side, input string tag);
    int n;
    logic [LW-1:0] data;
    n = 0;
    while (!(a_read || a_write) && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_grant_timeout"}, LW'(n < 20), LW'(1));
    repeat (lat) tick();
    data   = {8{$urandom()}};
    a_resp = 1'b1;
    a_line = data;
    #1;
    chk({tag, "_i_resp"}, LW'(i_resp), LW'(side == 1));
    chk({tag, "_d_resp"}, LW'(d_resp), LW'(side == 2));
    if (side == 1) chk({tag, "_i_line"}, i_line, data);
    else chk({tag, "_d_line"}, d_line, data);
    tick();
    a_resp = 1'b0;
  endtask

  logic [LW-1:0] pat_a5;
  logic [LW-1:0] pat_3c;

  initial begin
    checks  = 0;
    errors  = 0;
    pat_a5  = {32{8'hA5}};
    pat_3c  = {32{8'h3C}};
    rst     = 1'b1;
    i_read  = 1'b0;
    i_addr  = '0;
    d_read  = 1'b0;
    d_write = 1'b0;
    d_addr  = '0;
    d_wline = '0;
    a_line  = '0;
    a_resp  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_a_read", LW'(a_read), LW'(0));
    chk("rst_a_write", LW'(a_write), LW'(0));
    chk("rst_a_addr", LW'(a_addr), LW'(0));
    chk("rst_a_wline", a_wline, '0);

    // I-read only
    i_read = 1'b1;
    i_addr = 32'h0000_1000;
    tick();
    chk("iread_a_read", LW'(a_read), LW'(1));
    chk("iread_a_addr", LW'(a_addr), LW'(32'h0000_1000));
    serve(1, 1, "iread");
    i_read = 1'b0;

    // D-write only
    d_write = 1'b1;
    d_addr  = 32'h0000_2040;
    d_wline = pat_a5;
    tick();
    chk("dwr_a_write", LW'(a_write), LW'(1));
    chk("dwr_a_read", LW'(a_read), LW'(0));
    chk("dwr_a_wline", a_wline, pat_a5);
    chk("dwr_a_addr", LW'(a_addr), LW'(32'h0000_2040));
    serve(2, 2, "dwr");
    d_write = 1'b0;

    // Simultaneous tie: I first, one idle cycle, then D
    i_read = 1'b1;
    i_addr = 32'h0000_3000;
    d_read = 1'b1;
    d_addr = 32'h0000_4000;
    tick();
    chk("tie_first_addr", LW'(a_addr), LW'(32'h0000_3000));
    serve(2, 1, "tie_i");
    i_read = 1'b0;
    chk("tie_gap_a_read", LW'(a_read), LW'(0));
    tick();
    chk("tie_second_a_read", LW'(a_read), LW'(1));
    chk("tie_second_addr", LW'(a_addr), LW'(32'h0000_4000));
    serve(1, 2, "tie_d");
    d_read = 1'b0;

    // Both held for four transfers: I, D, I, D
    begin
      int base;
      base   = grants.size();
      i_read = 1'b1;
      d_read = 1'b1;
      serve(1, 1, "rr0");
      serve(2, 2, "rr1");
      serve(0, 1, "rr2");
      serve(3, 2, "rr3");
      i_read = 1'b0;
      d_read = 1'b0;
      chk("rr_count", LW'(grants.size() - base), LW'(4));
      if (grants.size() >= base + 4) begin
        chk("rr_g0", LW'(grants[base]), LW'(1));
        chk("rr_g1", LW'(grants[base+1]), LW'(2));
        chk("rr_g2", LW'(grants[base+2]), LW'(1));
        chk("rr_g3", LW'(grants[base+3]), LW'(2));
      end
    end

    // D drops its write and changes address mid-transfer
    tick();
    d_write = 1'b1;
    d_addr  = 32'h0000_5000;
    d_wline = pat_3c;
    tick();
    d_write = 1'b0;
    d_addr  = 32'h0000_6000;
    d_wline = pat_a5;
    tick();
    chk("drop_a_write", LW'(a_write), LW'(1));
    chk("drop_a_addr", LW'(a_addr), LW'(32'h0000_5000));
    chk("drop_a_wline", a_wline, pat_3c);
    serve(1, 2, "drop");

    // Reset mid-transfer, off-edge
    i_read = 1'b1;
    i_addr = 32'h0000_7000;
    tick();
    chk("mid_pre_a_read", LW'(a_read), LW'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_a_read", LW'(a_read), LW'(0));
    chk("mid_rst_a_write", LW'(a_write), LW'(0));
    chk("mid_rst_a_addr", LW'(a_addr), LW'(0));
    i_read = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    i_read = 1'b1;
    i_addr = 32'h0000_8000;
    d_read = 1'b1;
    d_addr = 32'h0000_9000;
    tick();
    chk("post_rst_tie_addr", LW'(a_addr), LW'(32'h0000_8000));
    chk("post_rst_tie_read", LW'(a_read), LW'(1));
    serve(1, 1, "post_rst");
    i_read = 1'b0;
    d_read = 1'b0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cacheline_arbiter.md
# cacheline_arbiter

Shares the single cacheline adaptor between the instruction cache (read-only requester) and the data cache (read/write requester). It arbitrates round-robin and latches the winner's address, operation and write line at grant. It forwards the operation to the adaptor, then routes the adaptor's one-cycle response back to the winner only. It sits between the two L1 caches and `cacheline_adaptor`.

## Interface
- `ADDR_W`, 32, address width.
- `LINE_W`, 256, cacheline width.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `i_read`  in  1  I-cache line read request; held until `i_resp`.
- `i_addr`  in  ADDR_W  I-cache line address.
- `i_line`  out  LINE_W  read data to I-cache.
- `i_resp`  out  1  I-cache completion pulse.
- `d_read`, `d_write`  in  1  D-cache requests; one-hot or zero; held until `d_resp`.
- `d_addr`  in  ADDR_W  D-cache line address.
- `d_wline`  in  LINE_W  D-cache write line.
- `d_line`  out  LINE_W  read data to D-cache.
- `d_resp`  out  1  D-cache completion pulse.
- `a_read`, `a_write`  out  1  requests to the adaptor.
- `a_addr`  out  ADDR_W  address to the adaptor.
- `a_wline`  out  LINE_W  write line to the adaptor.
- `a_line`  in  LINE_W  read line from the adaptor.
- `a_resp`  in  1  adaptor completion pulse.

## Operation
- States:
  - `IDLE`: no adaptor request.
  - `BUSY_I`: I-cache owns the adaptor.
  - `BUSY_D`: D-cache owns the adaptor.
- Registers:
  - `state`
  - `last` (0 = I served last, 1 = D served last)
  - `op_wr`, `op_addr`, `op_line` (latched request)
- Decisions are taken only in `IDLE`:
  - Only I pending → `BUSY_I`.
  - Only D pending → `BUSY_D`.
  - Both pending → grant the side not equal to `last`.
  - Nothing pending → stay in `IDLE`.
- On grant:
  - latch `op_addr` from the winner's address;
  - latch `op_wr` = `d_write` for D, 0 for I;
  - latch `op_line` = `d_wline` for a D write, else hold.
- In `BUSY_x`:
  - drive `a_read` = !`op_wr`, `a_write` = `op_wr`, `a_addr` = `op_addr`, `a_wline` = `op_line`;
  - on `a_resp` = 1: pulse the winner's resp the same cycle (combinational), set `last`, go to `IDLE`.
- `i_line` and `d_line` = `a_line` at all times; consumers qualify the data with their own resp.
- The loser's resp is always 0.
- A requester that drops its request mid-transfer is a protocol violation. The arbiter does not abort: it completes from latched values, and the resp pulse is still issued.
- `d_read` and `d_write` both high is illegal; `d_write` wins.

## Timing
- Reset values:
  - `state` = `IDLE`, `last` = 1 (I wins the first tie).
  - `op_*` = 0.
  - All outputs 0 (`a_*`, `i_resp`, `d_resp`); `i_line`/`d_line` follow `a_line`.
- Grant latency: request seen in `IDLE` at edge t → adaptor request high from t+1.
- Completion: `a_resp` at cycle c → winner's resp at c → `IDLE` at c+1, during which `a_read`/`a_write` = 0.
  - This guaranteed one-cycle gap lets the requester drop its request before re-arbitration.
  - Without it, a still-high request would be double-served.
- Back-to-back: the other pending requester is granted at c+2 from the `IDLE` decision at c+1.
- Asynchronous reset mid-transfer: outputs return to 0 immediately. The adaptor's own reset must be asserted by the top level in the same cycle.

## Structure
- Package `cache_arb_pkg`:
  - `arb_state_t` enum (`IDLE`, `BUSY_I`, `BUSY_D`).
  - `requester_t` enum (`REQ_I` = 0, `REQ_D` = 1).
  - `LINE_W` and `ADDR_W` defaults.
- No sub-module. The round-robin pick is a few gates inside this block.

## Test plan
- Reset, then I-read only, `i_addr` = 0x0000_1000 → `a_read` = 1 with `a_addr` = 0x0000_1000 one cycle later; at the `a_resp` pulse, `i_resp` = 1, `i_line` = `a_line`, `d_resp` = 0.
- D-write only, `d_addr` = 0x0000_2040, `d_wline` = 0xA5… → `a_write` = 1 with `a_wline` = 0xA5…; `d_resp` pulses with `a_resp`.
- I-read and D-read asserted in the same cycle after reset → I granted first; D granted at resp + 2 cycles; `a_read` is low for exactly one cycle between the two transfers.
- Both pending continuously for 4 transfers → grant order I, D, I, D.
- D drops `d_write` and changes `d_addr` mid-transfer → `a_write` and `a_addr` stay at the latched values until `a_resp`.
- `rst` asserted mid-transfer, off-edge → all `a_*` outputs 0 immediately; the first tie after release grants I.
